// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V style controller: FSM states,
// opcode constants and the select/control codes driven to the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JAL, JALR_ADR, JALR_PC, LUI, HALT
  } state_t;

  // Which ALU operation family the current state asks for
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  // States that talk to memory and therefore stretch by the wait latency
  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the ALU operation family of the current state plus func3/func7 to an
// ALU control code. The illegal flag depends on func3 alone so the decode
// state can route unsupported R/I encodings to HALT.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t    cls,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  output logic [2:0]  alu_control,
  output logic        illegal
);

  logic [2:0] func_op;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Translate func3 (and func7[5] for R-type subtract) into an ALU operation
  always_comb begin
    func_op = ALU_ADD;
    illegal = 1'b0;
    case (func3)
      3'b000:  func_op = (cls == CLS_R && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  func_op = ALU_AND;
      3'b110:  func_op = ALU_OR;
      3'b100:  func_op = ALU_XOR;
      3'b010:  func_op = ALU_SLT;
      3'b011:  func_op = ALU_SLTU;
      default: illegal = 1'b1;
    endcase
  end

  // Select between fixed add/sub and the func3-decoded operation
  always_comb begin
    alu_control = ALU_ADD;
    case (cls)
      CLS_SUB:      alu_control = ALU_SUB;
      CLS_R, CLS_I: alu_control = func_op;
      default:      alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle RV32I-subset datapath. Memory states
// (FETCH, MEM_READ, MEM_WRITE) hold for MEM_LAT extra cycles; their write
// strobes fire only in the last cycle. Write enables are forced low while
// rst is high so a reset mid-access never commits a write.
module multi_cycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       alu_sign,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       adr_src,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       halted
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, next;
  logic [3:0] wait_cnt;
  logic       wait_done;
  alu_cls_t   cls;
  logic       illegal;
  logic       pc_wr_raw, ir_wr_raw, mem_wr_raw, reg_wr_raw, halted_raw;

  assign wait_done = (wait_cnt == LAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  // Wait counter: counts within a memory state, clears when leaving it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wait_cnt <= '0;
    else if (is_mem_state(state) && !wait_done) wait_cnt <= wait_cnt + 4'd1;
    else                                      wait_cnt <= '0;
  end

  // ALU operation family requested by each state
  always_comb begin
    cls = CLS_ADD;
    case (state)
      BRANCH:  cls = CLS_SUB;
      EXEC_R:  cls = CLS_R;
      EXEC_I:  cls = CLS_I;
      default: cls = CLS_ADD;
    endcase
  end

  alu_op_decoder u_alu_dec (
    .cls         (cls),
    .func3       (func3),
    .func7       (func7),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  // Next-state and Moore outputs
  always_comb begin
    next       = state;
    pc_wr_raw  = 1'b0;
    ir_wr_raw  = 1'b0;
    mem_wr_raw = 1'b0;
    reg_wr_raw = 1'b0;
    halted_raw = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    case (state)
      FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (wait_done) begin
          ir_wr_raw = 1'b1;
          pc_wr_raw = 1'b1;
          next      = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: next = MEM_ADR;
          OP_RTYPE:          next = illegal ? HALT : EXEC_R;
          OP_ITYPE:          next = illegal ? HALT : EXEC_I;
          OP_BRANCH:         next = BRANCH;
          OP_JAL:            next = JAL;
          OP_JALR:           next = JALR_ADR;
          OP_LUI:            next = LUI;
          default:           next = HALT;
        endcase
      end
      MEM_ADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
        next      = (op == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        if (wait_done) next = MEM_WB;
      end
      MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_wr_raw = 1'b1;
        next       = FETCH;
      end
      MEM_WRITE: begin
        adr_src = 1'b1;
        if (wait_done) begin
          mem_wr_raw = 1'b1;
          next       = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RD1;
        next      = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        next      = ALU_WB;
      end
      ALU_WB: begin
        reg_wr_raw = 1'b1;
        next       = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RD1;
        case (func3)
          3'b000:  pc_wr_raw = zero;
          3'b001:  pc_wr_raw = !zero;
          3'b100:  pc_wr_raw = alu_sign;
          3'b101:  pc_wr_raw = !alu_sign;
          default: pc_wr_raw = 1'b0;
        endcase
        next = FETCH;
      end
      JAL, JALR_PC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_wr_raw = 1'b1;
        next      = ALU_WB;
      end
      JALR_ADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        next      = JALR_PC;
      end
      LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_wr_raw = 1'b1;
        next       = FETCH;
      end
      HALT: begin
        halted_raw = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  assign pc_wr  = pc_wr_raw  & ~rst;
  assign ir_wr  = ir_wr_raw  & ~rst;
  assign mem_wr = mem_wr_raw & ~rst;
  assign reg_wr = reg_wr_raw & ~rst;
  assign halted = halted_raw & ~rst;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: one instance with no memory latency and
// one with two wait cycles. Each instruction is expanded by a reference model
// into its expected per-cycle control word sequence, then compared cycle by
// cycle against the DUT.
module tb_multi_cycle_controller;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                         ITYP = 7'b0010011, BRN = 7'b1100011, JALO = 7'b1101111,
                         JALRO = 7'b1100111, LUIO = 7'b0110111;

  typedef logic [17:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] op_v [2];
  logic [2:0] f3_v [2];
  logic [6:0] f7_v [2];
  logic       z_v  [2];
  logic       s_v  [2];

  logic [1:0]      pc_o, ir_o, adr_o, mw_o, rw_o, halt_o;
  logic [1:0][1:0] a_o, b_o, res_o;
  logic [1:0][2:0] alu_o, imm_o;

  int n_checks = 0;
  int n_errors = 0;

  multi_cycle_controller #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .op(op_v[0]), .func3(f3_v[0]), .func7(f7_v[0]),
    .zero(z_v[0]), .alu_sign(s_v[0]), .pc_wr(pc_o[0]), .ir_wr(ir_o[0]),
    .adr_src(adr_o[0]), .mem_wr(mw_o[0]), .reg_wr(rw_o[0]), .alu_src_a(a_o[0]),
    .alu_src_b(b_o[0]), .alu_control(alu_o[0]), .imm_src(imm_o[0]),
    .result_src(res_o[0]), .halted(halt_o[0])
  );

  multi_cycle_controller #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .op(op_v[1]), .func3(f3_v[1]), .func7(f7_v[1]),
    .zero(z_v[1]), .alu_sign(s_v[1]), .pc_wr(pc_o[1]), .ir_wr(ir_o[1]),
    .adr_src(adr_o[1]), .mem_wr(mw_o[1]), .reg_wr(rw_o[1]), .alu_src_a(a_o[1]),
    .alu_src_b(b_o[1]), .alu_control(alu_o[1]), .imm_src(imm_o[1]),
    .result_src(res_o[1]), .halted(halt_o[1])
  );

  // Control word layout: {pc,ir,adr,mem_wr,reg_wr,src_a,src_b,alu,imm,res,halted}
  function automatic logic [17:0] w(bit pc, bit ir, bit adr, bit mw, bit rw,
                                    logic [1:0] a, logic [1:0] b, logic [2:0] alu,
                                    logic [2:0] imm, logic [1:0] res, bit h);
    return {pc, ir, adr, mw, rw, a, b, alu, imm, res, h};
  endfunction

  function automatic logic [17:0] obs(int d);
    return {pc_o[d], ir_o[d], adr_o[d], mw_o[d], rw_o[d], a_o[d], b_o[d],
            alu_o[d], imm_o[d], res_o[d], halt_o[d]};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU code for R/I instructions straight from the func3 table
  function automatic bit alu_ref(bit is_r, logic [2:0] f3, logic [6:0] f7,
                                 output logic [2:0] alu);
    alu = 3'b000;
    case (f3)
      3'b000: alu = (is_r && f7[5]) ? 3'b001 : 3'b000;
      3'b111: alu = 3'b010;
      3'b110: alu = 3'b011;
      3'b100: alu = 3'b100;
      3'b010: alu = 3'b101;
      3'b011: alu = 3'b110;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected control-word sequence of one instruction at a given latency
  function automatic word_q_t build(int lat, logic [6:0] o, logic [2:0] f3,
                                    logic [6:0] f7, bit z, bit s);
    word_q_t q;
    logic [2:0] alu;
    bit legal, taken;
    logic [17:0] hlt = w(0,0,0,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,1);
    logic [17:0] wb  = w(0,0,0,0,1,2'b00,2'b00,3'b000,3'b000,2'b00,0);
    logic [17:0] jmp = w(1,0,0,0,0,2'b01,2'b10,3'b000,3'b000,2'b00,0);
    repeat (lat) q.push_back(w(0,0,0,0,0,2'b00,2'b10,3'b000,3'b000,2'b10,0));
    q.push_back(w(1,1,0,0,0,2'b00,2'b10,3'b000,3'b000,2'b10,0));
    q.push_back(w(0,0,0,0,0,2'b01,2'b01,3'b000,3'b010,2'b00,0));
    case (o)
      LOAD: begin
        q.push_back(w(0,0,0,0,0,2'b10,2'b01,3'b000,3'b000,2'b00,0));
        repeat (lat + 1) q.push_back(w(0,0,1,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,0));
        q.push_back(w(0,0,0,0,1,2'b00,2'b00,3'b000,3'b000,2'b01,0));
      end
      STORE: begin
        q.push_back(w(0,0,0,0,0,2'b10,2'b01,3'b000,3'b001,2'b00,0));
        repeat (lat) q.push_back(w(0,0,1,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,0));
        q.push_back(w(0,0,1,1,0,2'b00,2'b00,3'b000,3'b000,2'b00,0));
      end
      RTYP, ITYP: begin
        legal = alu_ref(o == RTYP, f3, f7, alu);
        if (!legal) repeat (3) q.push_back(hlt);
        else begin
          q.push_back(w(0,0,0,0,0,2'b10,(o == RTYP) ? 2'b00 : 2'b01, alu, 3'b000, 2'b00, 0));
          q.push_back(wb);
        end
      end
      BRN: begin
        case (f3)
          3'b000:  taken = z;
          3'b001:  taken = !z;
          3'b100:  taken = s;
          3'b101:  taken = !s;
          default: taken = 1'b0;
        endcase
        q.push_back(w(taken,0,0,0,0,2'b10,2'b00,3'b001,3'b000,2'b00,0));
      end
      JALO: begin
        q.push_back(jmp);
        q.push_back(wb);
      end
      JALRO: begin
        q.push_back(w(0,0,0,0,0,2'b10,2'b01,3'b000,3'b000,2'b00,0));
        q.push_back(jmp);
        q.push_back(wb);
      end
      LUIO: q.push_back(w(0,0,0,0,1,2'b00,2'b00,3'b000,3'b100,2'b11,0));
      default: repeat (3) q.push_back(hlt);
    endcase
    return q;
  endfunction

  // Drive one instruction and compare each cycle (ncheck=0: whole sequence)
  task automatic run_instr(int d, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                           bit z, bit s, int ncheck, output bit halted_out);
    word_q_t q;
    int n;
    q = build((d == 0) ? 0 : 2, o, f3, f7, z, s);
    op_v[d] = o; f3_v[d] = f3; f7_v[d] = f7; z_v[d] = z; s_v[d] = s;
    n = (ncheck == 0) ? q.size() : ncheck;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("d%0d op=%b f3=%0d cyc%0d", d, o, f3, i + 1), 32'(obs(d)), 32'(q[i]));
      if (ncheck == 0 || i < n - 1) begin
        @(posedge clk);
        #1;
      end
    end
    halted_out = q[q.size() - 1][0];
  endtask

  // Hold reset across one edge; both instances must sit in gated FETCH
  task automatic do_reset();
    logic [17:0] rst_w = w(0,0,0,0,0,2'b00,2'b10,3'b000,3'b000,2'b10,0);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_eq($sformatf("reset d%0d", d), 32'(obs(d)), 32'(rst_w));
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_eq($sformatf("reset hold d%0d", d), 32'(obs(d)), 32'(rst_w));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit h;
    logic [6:0] ops [9];
    logic [6:0] o;
    ops = '{LOAD, STORE, RTYP, ITYP, BRN, JALO, JALRO, LUIO, 7'b0000000};
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      op_v[d] = '0; f3_v[d] = '0; f7_v[d] = '0; z_v[d] = 1'b0; s_v[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // add x3,x1,x2 then beq/bne with zero set, no latency
    run_instr(0, RTYP, 3'b000, 7'h00, 0, 0, 0, h);
    run_instr(0, BRN, 3'b000, 7'h00, 1, 0, 0, h);
    run_instr(0, BRN, 3'b001, 7'h00, 1, 0, 0, h);
    // undefined opcode halts until reset, then execution restarts
    run_instr(0, 7'b1111111, 3'b000, 7'h00, 0, 0, 0, h);
    do_reset();
    run_instr(0, LUIO, 3'b000, 7'h00, 0, 0, 0, h);

    // lw with two wait cycles per memory access
    do_reset();
    run_instr(1, LOAD, 3'b010, 7'h00, 0, 0, 0, h);
    // sw interrupted by reset in its final write cycle
    run_instr(1, STORE, 3'b010, 7'h00, 0, 0, 8, h);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mem_wr under reset", 32'(mw_o[1]), 32'd0);
    check_eq("word under reset", 32'(obs(1)), 32'(w(0,0,0,0,0,2'b00,2'b10,3'b000,3'b000,2'b10,0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(1, ITYP, 3'b111, 7'h00, 0, 0, 0, h);

    // random instruction streams on both latencies
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int k = 0; k < 40; k++) begin
        o = ops[$urandom_range(0, 8)];
        if (o == 7'b0000000) o = 7'($urandom_range(0, 127));
        run_instr(d, o, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 1) ? 7'h20 : 7'($urandom_range(0, 127)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, h);
        if (h) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
